// File: rtl/systolic_feeder.sv
// rtl/systolic_feeder.sv - skews activation column vectors into a systolic array, one row per PE row.
// Optional macro FEEDER_STALL_CNT_EN adds a saturating count of starved FEED cycles on stall_cnt.
module systolic_feeder #(
   parameter int PE_ROW           = 16,
   parameter int INPUT_DATA_WIDTH = 8,
   parameter int LEN_WIDTH        = 8
) (
   input  logic                               clk,
   input  logic                               rstn,
   input  logic                               start,
   input  logic [LEN_WIDTH-1:0]               len,
   input  logic                               in_valid,
   output logic                               in_ready,
   input  logic [INPUT_DATA_WIDTH*PE_ROW-1:0] in_data,
   output logic [INPUT_DATA_WIDTH*PE_ROW-1:0] out_a_bus,
   output logic [PE_ROW-1:0]                  enable,
   output logic                               save,
   output logic                               busy,
   output logic                               done
`ifdef FEEDER_STALL_CNT_EN
   ,
   output logic [15:0]                        stall_cnt
`endif
);

   localparam int W  = INPUT_DATA_WIDTH;
   localparam int DW = $clog2(PE_ROW + 1);

   typedef enum logic [1:0] {IDLE, FEED, DRAIN, SAVE} state_t;

   state_t               state, next_state;
   logic [LEN_WIDTH-1:0] beat_cnt;
   logic [DW-1:0]        drain_cnt;
   logic                 start_ok;
   logic                 accept;

   assign start_ok = (state == IDLE) && start && (len != '0);
   assign accept   = (state == FEED) && in_valid;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) state <= IDLE;
      else       state <= next_state;
   end

   always_comb begin
      next_state = state;
      in_ready   = 1'b0;
      busy       = 1'b1;
      save       = 1'b0;
      done       = 1'b0;
      case (state)
         IDLE: begin
            busy = 1'b0;
            if (start_ok) next_state = FEED;
         end
         FEED: begin
            in_ready = 1'b1;
            if (accept && beat_cnt == LEN_WIDTH'(1)) next_state = DRAIN;
         end
         DRAIN: begin
            if (drain_cnt == DW'(1)) next_state = SAVE;
         end
         SAVE: begin
            save       = 1'b1;
            done       = 1'b1;
            next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         beat_cnt  <= '0;
         drain_cnt <= '0;
      end else begin
         if (start_ok)    beat_cnt <= len;
         else if (accept) beat_cnt <= beat_cnt - LEN_WIDTH'(1);

         // Drain runs PE_ROW cycles so the deepest row flushes its final beat.
         if (accept && beat_cnt == LEN_WIDTH'(1)) drain_cnt <= DW'(PE_ROW);
         else if (state == DRAIN)                 drain_cnt <= drain_cnt - DW'(1);
      end
   end

`ifdef FEEDER_STALL_CNT_EN
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)
         stall_cnt <= '0;
      else if (start_ok)
         stall_cnt <= '0;
      else if (state == FEED && !in_valid && stall_cnt != 16'hFFFF)
         stall_cnt <= stall_cnt + 16'd1;
   end
`endif

   // Row r delays by r+1 registers; invalid slots carry zero data so a low enable always sees 0.
   for (genvar r = 0; r < PE_ROW; r++) begin : g_row
      logic [W-1:0] d_q [0:r];
      logic         v_q [0:r];

      always_ff @(posedge clk or negedge rstn) begin
         if (!rstn) begin
            for (int s = 0; s <= r; s++) begin
               d_q[s] <= '0;
               v_q[s] <= 1'b0;
            end
         end else begin
            d_q[0] <= accept ? in_data[r*W +: W] : '0;
            v_q[0] <= accept;
            for (int s = 1; s <= r; s++) begin
               d_q[s] <= d_q[s-1];
               v_q[s] <= v_q[s-1];
            end
         end
      end

      assign out_a_bus[r*W +: W] = d_q[r];
      assign enable[r]           = v_q[r];
   end

endmodule

// File: tb/tb_systolic_feeder.sv
// tb/tb_systolic_feeder.sv - randomized and directed self-checking bench for systolic_feeder.
module tb_systolic_feeder;
   localparam int R  = 16;
   localparam int W  = 8;
   localparam int LW = 8;
   localparam int DB = R * W;

   logic          clk = 1'b0;
   logic          rstn = 1'b0;
   logic          start = 1'b0;
   logic [LW-1:0] len = '0;
   logic          in_valid = 1'b0;
   logic [DB-1:0] in_data = '0;
   logic          in_ready, save, busy, done;
   logic [DB-1:0] out_a_bus;
   logic [R-1:0]  enable;
`ifdef FEEDER_STALL_CNT_EN
   logic [15:0]   stall_cnt;
`endif

   systolic_feeder #(.PE_ROW(R), .INPUT_DATA_WIDTH(W), .LEN_WIDTH(LW)) dut (
      .clk(clk), .rstn(rstn), .start(start), .len(len), .in_valid(in_valid),
      .in_ready(in_ready), .in_data(in_data), .out_a_bus(out_a_bus), .enable(enable),
      .save(save), .busy(busy), .done(done)
`ifdef FEEDER_STALL_CNT_EN
      , .stall_cnt(stall_cnt)
`endif
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;
   int k = 100;

   // Model: history of what entered the array each cycle, plus tile bookkeeping.
   logic [DB-1:0] ring_d [0:63];
   logic          ring_v [0:63];
   bit            m_tile;
   int            m_left;
   int            m_save;
   int            m_stall;
   int            last_save = -1;
   bit            b2b = 0;

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s cycle %0d: got %h expected %h", name, k, act, exp);
      end
   endtask

   task automatic model_clear();
      for (int i = 0; i < 64; i++) begin
         ring_d[i] = '0;
         ring_v[i] = 1'b0;
      end
      m_tile  = 0;
      m_left  = 0;
      m_save  = -1;
      m_stall = 0;
   endtask

   function automatic logic [DB-1:0] rnd_vec();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic tick(input bit st, input logic [LW-1:0] ln, input bit iv, input logic [DB-1:0] d);
      logic [DB-1:0] eb;
      logic [R-1:0]  ee;
      bit            acc;
      @(negedge clk);
      for (int i = 0; i < R; i++) begin
         ee[i]         = ring_v[(k - 1 - i) & 63];
         eb[i*W +: W]  = ring_d[(k - 1 - i) & 63][i*W +: W];
      end
      chk("out_a_bus", out_a_bus, eb);
      chk("enable", enable, ee);
      chk("in_ready", in_ready, m_tile && m_left > 0);
      chk("busy", busy, m_tile);
      chk("save", save, m_tile && k == m_save);
      chk("done", done, m_tile && k == m_save);
`ifdef FEEDER_STALL_CNT_EN
      chk("stall_cnt", stall_cnt, m_stall);
`endif
      if (b2b && save) begin
         if (last_save >= 0) chk("save_spacing", k - last_save, R + 3);
         last_save = k;
      end
      start = st; len = ln; in_valid = iv; in_data = d;
      acc = rstn && m_tile && m_left > 0 && iv;
      ring_d[k & 63] = acc ? d : '0;
      ring_v[k & 63] = acc;
      if (!rstn) model_clear();
      else if (!m_tile) begin
         if (st && ln != 0) begin
            m_tile = 1; m_left = ln; m_save = -1; m_stall = 0;
         end
      end else if (k == m_save) m_tile = 0;
      else if (m_left > 0) begin
         if (acc) begin
            m_left--;
            if (m_left == 0) m_save = k + R + 1;
         end else if (m_stall < 65535) m_stall++;
      end
      @(posedge clk);
      k++;
   endtask

   task automatic idle(input int n, input bit iv);
      for (int i = 0; i < n; i++) tick(0, 0, iv, rnd_vec());
   endtask

   logic [DB-1:0] dvec;
   logic [DB-1:0] one_wide;

   initial begin
      model_clear();
      one_wide = 1;
      idle(3, 0);
      #1;
      chk("reset_busy", busy, 0);
      chk("reset_enable", enable, 0);
      rstn = 1'b1;
      idle(2, 0);

      // Single beat, rows carry i+1: literal timing of every row and the save pulse.
      for (int i = 0; i < R; i++) dvec[i*W +: W] = W'(i + 1);
      tick(1, 1, 0, '0);
      tick(0, 0, 1, dvec);
      for (int i = 0; i < R; i++) begin
         if (i > 0) idle(1, 0);
         #1;
         chk("lit_enable", enable, (R)'(1) << i);
         chk("lit_bus", out_a_bus, (DB)'(i + 1) << (i * W));
      end
      idle(1, 0);
      #1;
      chk("lit_save", {save, done}, 2'b11);
      idle(1, 0);
      #1;
      chk("lit_busy_low", busy, 0);
      idle(3, 0);

      // Gapped tile.
      tick(1, 4, 0, '0);
      tick(0, 0, 1, rnd_vec());
      tick(0, 0, 0, rnd_vec());
      tick(0, 0, 1, rnd_vec());
      tick(0, 0, 1, rnd_vec());
      tick(0, 0, 1, rnd_vec());
      idle(25, 0);

      // len=0 ignored; start during FEED ignored.
      tick(1, 0, 1, rnd_vec());
      #1;
      chk("len0_busy", busy, 0);
      chk("len0_ready", in_ready, 0);
      tick(1, 3, 0, '0);
      tick(1, 9, 1, rnd_vec());
      tick(1, 9, 1, rnd_vec());
      tick(0, 0, 1, rnd_vec());
      idle(25, 1);

      // Reset mid-tile.
      tick(1, 8, 0, '0);
      tick(0, 0, 1, rnd_vec());
      tick(0, 0, 1, rnd_vec());
      tick(0, 0, 1, rnd_vec());
      #1;
      rstn = 1'b0;
      #1;
      chk("rst_bus", out_a_bus, 0);
      chk("rst_outs", {enable, busy, in_ready, save, done}, 0);
      model_clear();
      idle(2, 1);
      #1;
      rstn = 1'b1;
      tick(1, 2, 0, '0);
      idle(25, 1);

`ifdef FEEDER_STALL_CNT_EN
      tick(1, 2, 0, '0);
      idle(5, 0);
      idle(2, 1);
      idle(16, 0);
      #1;
      chk("lit_stall_done", {done, stall_cnt}, {1'b1, 16'd5});
      idle(1, 0);
      tick(1, 1, 0, '0);
      #1;
      chk("lit_stall_clear", stall_cnt, 0);
      idle(20, 1);
`endif

      // Back-to-back tiles with start held high.
      b2b = 1;
      for (int i = 0; i < 80; i++) tick(1, 1, 1, rnd_vec());
      b2b = 0;
      idle(25, 1);

      // Randomized traffic.
      for (int i = 0; i < 2000; i++)
         tick(($urandom % 4) == 0, LW'($urandom % 7), ($urandom % 5) != 0, rnd_vec());
      idle(40, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
